// File: rtl/stream_to_axi_ax.sv
// Replays snooped {type, id, len, pad, addr} stream beats as AXI4 AR/AW address transactions
// through a 2-entry FIFO. Optional discard counter enabled by `define STREAM_TO_AX_DROP_CNT_EN.
module stream_to_axi_ax #(
   parameter int                           DATA_WIDTH        = 128,
   parameter int                           ADDR_WIDTH        = 64,
   parameter int                           ID_WIDTH          = 32,
   parameter int                           BURST_LEN         = 8,
   parameter int                           LOCK_WIDTH        = 2,
   parameter int                           USER_WIDTH        = 64,
   parameter int                           STREAM_TYPE_WIDTH = 3,
   parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = '0,
   parameter logic [2:0]                   AXSIZE            = 3'b100,
   parameter logic [1:0]                   AXBURST           = 2'b01
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] S_tdata,
   input  logic                  S_tvalid,
   input  logic                  S_tlast,
   output logic                  S_tready,
   output logic [ID_WIDTH-1:0]   AXIM_axid,
   output logic [ADDR_WIDTH-1:0] AXIM_axaddr,
   output logic [BURST_LEN-1:0]  AXIM_axlen,
   output logic [2:0]            AXIM_axsize,
   output logic [1:0]            AXIM_axburst,
   output logic [LOCK_WIDTH-1:0] AXIM_axlock,
   output logic [3:0]            AXIM_axcache,
   output logic [2:0]            AXIM_axprot,
   output logic [3:0]            AXIM_axregion,
   output logic [3:0]            AXIM_axqos,
   output logic [USER_WIDTH-1:0] AXIM_axuser,
   output logic                  AXIM_axvalid,
   input  logic                  AXIM_axready,
   output logic [15:0]           drop_count,
   output logic [1:0]            fifo_level
);

   localparam int TYPE_LSB = DATA_WIDTH - STREAM_TYPE_WIDTH;
   localparam int ID_LSB   = TYPE_LSB - ID_WIDTH;
   localparam int LEN_LSB  = ID_LSB - BURST_LEN;

   // The FIFO level is the FSM state; it is exposed directly on fifo_level.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   fifo_state_t state_q, state_d;

   logic                          rd_ptr, wr_ptr;
   logic [ID_WIDTH-1:0]           id_mem   [2];
   logic [BURST_LEN-1:0]          len_mem  [2];
   logic [ADDR_WIDTH-1:0]         addr_mem [2];

   logic [STREAM_TYPE_WIDTH-1:0]  beat_type;
   logic [ID_WIDTH-1:0]           beat_id;
   logic [BURST_LEN-1:0]          beat_len;
   logic [ADDR_WIDTH-1:0]         beat_addr;
   logic                          accept, match, push, pop;
   logic                          tdata_unused;

   assign beat_type    = S_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
   assign beat_id      = S_tdata[TYPE_LSB-1 -: ID_WIDTH];
   assign beat_len     = S_tdata[ID_LSB-1 -: BURST_LEN];
   assign beat_addr    = S_tdata[ADDR_WIDTH-1:0];
   assign tdata_unused = ^S_tdata;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // S_tready depends only on registered level (never on AXIM_axready); AXIM_axvalid and
   // the head entry hold steady until AXIM_axready is seen.
   assign S_tready     = !reset && (state_q != FULL);
   assign AXIM_axvalid = (state_q != EMPTY);
   assign accept       = S_tvalid && S_tready;
   assign match        = (beat_type == STREAM_TYPE) && S_tlast;
   assign push         = accept && match;
   assign pop          = AXIM_axvalid && AXIM_axready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // FULL never pushes because S_tready is low there.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:  if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            id_mem[i]   <= '0;
            len_mem[i]  <= '0;
            addr_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            id_mem[wr_ptr]   <= beat_id;
            len_mem[wr_ptr]  <= beat_len;
            addr_mem[wr_ptr] <= beat_addr;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   assign AXIM_axid     = id_mem[rd_ptr];
   assign AXIM_axlen    = len_mem[rd_ptr];
   assign AXIM_axaddr   = addr_mem[rd_ptr];
   assign AXIM_axsize   = AXSIZE;
   assign AXIM_axburst  = AXBURST;
   assign AXIM_axlock   = '0;
   assign AXIM_axcache  = '0;
   assign AXIM_axprot   = '0;
   assign AXIM_axregion = '0;
   assign AXIM_axqos    = '0;
   assign AXIM_axuser   = '0;
   assign fifo_level    = state_q;

`ifdef STREAM_TO_AX_DROP_CNT_EN
   logic [15:0] drop_q;
   logic        drop;

   assign drop = accept && !match;

   // Saturates so a long burst of junk never makes the count look small again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_q <= '0;
      end else if (drop && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_stream_to_axi_ax.sv
// Directed self-checking bench for stream_to_axi_ax; expectations follow the
// STREAM_TO_AX_DROP_CNT_EN setting used for the build.
module tb_stream_to_axi_ax;

`ifdef STREAM_TO_AX_DROP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  S_tdata;
   logic          S_tvalid;
   logic          S_tlast;
   logic          S_tready;
   logic [31:0]   AXIM_axid;
   logic [63:0]   AXIM_axaddr;
   logic [7:0]    AXIM_axlen;
   logic [2:0]    AXIM_axsize;
   logic [1:0]    AXIM_axburst;
   logic [1:0]    AXIM_axlock;
   logic [3:0]    AXIM_axcache;
   logic [2:0]    AXIM_axprot;
   logic [3:0]    AXIM_axregion;
   logic [3:0]    AXIM_axqos;
   logic [63:0]   AXIM_axuser;
   logic          AXIM_axvalid;
   logic          AXIM_axready;
   logic [15:0]   drop_count;
   logic [1:0]    fifo_level;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_drops = 0;
   logic [31:0]   exp_q[$];

   stream_to_axi_ax dut (
      .clk           (clk),
      .reset         (reset),
      .S_tdata       (S_tdata),
      .S_tvalid      (S_tvalid),
      .S_tlast       (S_tlast),
      .S_tready      (S_tready),
      .AXIM_axid     (AXIM_axid),
      .AXIM_axaddr   (AXIM_axaddr),
      .AXIM_axlen    (AXIM_axlen),
      .AXIM_axsize   (AXIM_axsize),
      .AXIM_axburst  (AXIM_axburst),
      .AXIM_axlock   (AXIM_axlock),
      .AXIM_axcache  (AXIM_axcache),
      .AXIM_axprot   (AXIM_axprot),
      .AXIM_axregion (AXIM_axregion),
      .AXIM_axqos    (AXIM_axqos),
      .AXIM_axuser   (AXIM_axuser),
      .AXIM_axvalid  (AXIM_axvalid),
      .AXIM_axready  (AXIM_axready),
      .drop_count    (drop_count),
      .fifo_level    (fifo_level)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat layout: [127:125] type, [124:93] id, [92:85] len, [84:64] pad, [63:0] addr.
   function automatic logic [127:0] mk_beat(input logic [2:0] t, input logic [31:0] id,
                                            input logic [7:0] len, input logic [63:0] addr);
      logic [127:0] d;
      d          = '0;
      d[127:125] = t;
      d[124:93]  = id;
      d[92:85]   = len;
      d[63:0]    = addr;
      return d;
   endfunction

   function automatic logic [15:0] drop_exp(input int n);
      int s;
      if (!CNT_EN) return 16'h0;
      s = (n > 65535) ? 65535 : n;
      return s[15:0];
   endfunction

   // driver
   task automatic drive(input logic [127:0] d, input logic last);
      S_tdata  = d;
      S_tlast  = last;
      S_tvalid = 1'b1;
   endtask

   initial begin
      logic [127:0] beat_a, beat_b, beat_c;
      reset        = 1'b1;
      S_tdata      = '0;
      S_tvalid     = 1'b0;
      S_tlast      = 1'b0;
      AXIM_axready = 1'b0;
      beat_a = mk_beat(3'b000, 32'hA, 8'h01, 64'h1000);
      beat_b = mk_beat(3'b000, 32'hB, 8'h02, 64'h2000);
      beat_c = mk_beat(3'b000, 32'hC, 8'h03, 64'h3000);

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tready", S_tready, 0);
      check("rst_axvalid", AXIM_axvalid, 0);
      check("rst_level", fifo_level, 0);
      check("rst_drop", drop_count, 0);
      check("rst_axaddr", AXIM_axaddr, 0);
      check("rst_axsize", AXIM_axsize, 3'b100);
      check("rst_axburst", AXIM_axburst, 2'b01);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rel_tready", S_tready, 1);
      check("rel_axvalid", AXIM_axvalid, 0);

      // single transaction, slave always ready
      AXIM_axready = 1'b1;
      drive(mk_beat(3'b000, 32'h1234, 8'h0F, 64'hDEAD_BEEF_0000_1000), 1'b1);
      tick();
      S_tvalid = 1'b0;
      @(negedge clk);
      check("t1_axvalid", AXIM_axvalid, 1);
      check("t1_axid", AXIM_axid, 32'h1234);
      check("t1_axlen", AXIM_axlen, 8'h0F);
      check("t1_axaddr", AXIM_axaddr, 64'hDEAD_BEEF_0000_1000);
      check("t1_axsize", AXIM_axsize, 3'b100);
      check("t1_axburst", AXIM_axburst, 2'b01);
      check("t1_zero_fields", {AXIM_axlock, AXIM_axcache, AXIM_axprot, AXIM_axregion,
                               AXIM_axqos, AXIM_axuser}, 0);
      check("t1_level", fifo_level, 1);
      tick();
      @(negedge clk);
      check("t1_level_after", fifo_level, 0);
      check("t1_axvalid_after", AXIM_axvalid, 0);

      // backpressure: fill to two, third beat stalls, then drain in order
      AXIM_axready = 1'b0;
      drive(beat_a, 1'b1);
      tick();
      drive(beat_b, 1'b1);
      tick();
      drive(beat_c, 1'b1);
      @(negedge clk);
      check("bp_tready_full", S_tready, 0);
      check("bp_level_full", fifo_level, 2);
      check("bp_head_a", AXIM_axid, 32'hA);
      tick();
      @(negedge clk);
      check("bp_head_stable_id", AXIM_axid, 32'hA);
      check("bp_head_stable_addr", AXIM_axaddr, 64'h1000);
      check("bp_level_hold", fifo_level, 2);
      AXIM_axready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_head_b", AXIM_axid, 32'hB);
      check("bp_head_b_len", AXIM_axlen, 8'h02);
      check("bp_level_one", fifo_level, 1);
      check("bp_tready_one", S_tready, 1);
      tick();
      S_tvalid = 1'b0;
      @(negedge clk);
      check("bp_head_c", AXIM_axid, 32'hC);
      check("bp_head_c_addr", AXIM_axaddr, 64'h3000);
      check("bp_level_pushpop", fifo_level, 1);
      tick();
      @(negedge clk);
      check("bp_level_empty", fifo_level, 0);

      // discarded beats: wrong type, then missing tlast
      drive(mk_beat(3'b101, 32'h55, 8'h01, 64'h5000), 1'b1);
      tick();
      drive(mk_beat(3'b000, 32'h66, 8'h01, 64'h6000), 1'b0);
      tick();
      S_tvalid = 1'b0;
      n_drops += 2;
      @(negedge clk);
      check("drop_axvalid", AXIM_axvalid, 0);
      check("drop_level", fifo_level, 0);
      check("drop_count_2", drop_count, drop_exp(n_drops));

      // push and pop in the same cycle at level 1, across pointer wraps
      AXIM_axready = 1'b0;
      drive(mk_beat(3'b000, 32'h100, 8'h00, 64'h100), 1'b1);
      exp_q.push_back(32'h100);
      tick();
      AXIM_axready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(mk_beat(3'b000, 32'h100 + i, i[7:0], 64'h100 + 64'(i)), 1'b1);
         exp_q.push_back(32'h100 + i);
         @(negedge clk);
         check("pp_head", AXIM_axid, exp_q.pop_front());
         check("pp_level", fifo_level, 1);
         tick();
      end
      S_tvalid = 1'b0;
      @(negedge clk);
      check("pp_head_last", AXIM_axid, exp_q.pop_front());
      check("pp_len_last", AXIM_axlen, 8'h08);
      tick();
      @(negedge clk);
      check("pp_level_end", fifo_level, 0);
      check("pp_queue_empty", exp_q.size(), 0);

      // saturation of the discard counter
      drive(mk_beat(3'b011, 32'h0, 8'h0, 64'h0), 1'b1);
      repeat (100) tick();
      n_drops += 100;
      @(negedge clk);
      check("sat_count_102", drop_count, drop_exp(n_drops));
      repeat (65433) tick();
      n_drops += 65433;
      @(negedge clk);
      check("sat_count_ffff", drop_count, drop_exp(n_drops));
      repeat (7) tick();
      n_drops += 7;
      S_tvalid = 1'b0;
      @(negedge clk);
      check("sat_count_hold", drop_count, drop_exp(n_drops));
      check("sat_axvalid", AXIM_axvalid, 0);

      // asynchronous reset while full
      AXIM_axready = 1'b0;
      drive(beat_a, 1'b1);
      tick();
      drive(beat_b, 1'b1);
      tick();
      S_tvalid = 1'b0;
      @(negedge clk);
      check("ar_level_full", fifo_level, 2);
      reset = 1'b1;
      #1;
      check("ar_axvalid", AXIM_axvalid, 0);
      check("ar_tready", S_tready, 0);
      check("ar_level", fifo_level, 0);
      check("ar_drop", drop_count, 0);
      check("ar_axid", AXIM_axid, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ar_rel_tready", S_tready, 1);
      check("ar_rel_axvalid", AXIM_axvalid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
